// File: rtl/sirv_gnrl_pkg.sv
// Shared constants and helpers for the sirv general-purpose FIFO/pipe family.
package sirv_gnrl_pkg;

  localparam int FIFO_DP_MAX = 256;

  // Number of bits needed to index n distinct values (0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sirv_gnrl_wrap_ctr.sv
// Binary counter that wraps from MAX-1 back to 0; MAX need not be a power of 2.
module sirv_gnrl_wrap_ctr #(
  parameter int MAX = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] val
);

  logic [W-1:0] r_val;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_val <= '0;
    end else if (inc) begin
      r_val <= (r_val == W'(MAX - 1)) ? '0 : r_val + W'(1);
    end
  end

  assign val = r_val;

endmodule

// File: rtl/sirv_gnrl_fifo_lvl.sv
// Synchronous FIFO with any depth, registered occupancy, level flags, flush
// and optional empty-bypass. DP=0 degenerates to a pure pass-through.
module sirv_gnrl_fifo_lvl
  import sirv_gnrl_pkg::*;
#(
  parameter int DP        = 8,
  parameter int DW        = 32,
  parameter int CUT_READY = 0,
  parameter int BYPASS    = 0,
  parameter int MSKO      = 0,
  parameter int AF_LVL    = DP - 1,
  parameter int AE_LVL    = 1,
  localparam int CW       = (DP == 0) ? 1 : int'(clog2(DP + 1))
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty
);

  if (DP == 0) begin : g_pass
    assign o_vld  = i_vld;
    assign i_rdy  = o_rdy;
    assign o_dat  = ((MSKO != 0) && !i_vld) ? '0 : i_dat;
    assign count  = '0;
    assign full   = 1'b1;
    assign empty  = 1'b1;
    assign afull  = 1'b1;
    assign aempty = 1'b1;
  end else begin : g_fifo
    localparam int PW = (DP <= 1) ? 1 : int'(clog2(DP));

`ifndef SYNTHESIS
    if (DP > FIFO_DP_MAX) begin : g_bad_dp
      $error("sirv_gnrl_fifo_lvl: DP=%0d exceeds %0d", DP, FIFO_DP_MAX);
    end
    if (AF_LVL < 1 || AF_LVL > DP) begin : g_bad_af
      $error("sirv_gnrl_fifo_lvl: AF_LVL=%0d outside 1..%0d", AF_LVL, DP);
    end
    if (AE_LVL < 0 || AE_LVL >= AF_LVL) begin : g_bad_ae
      $error("sirv_gnrl_fifo_lvl: AE_LVL=%0d must be below AF_LVL=%0d", AE_LVL, AF_LVL);
    end
`endif

    logic [DW-1:0] r_mem [DP];
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_rptr;
    logic [PW-1:0] w_wptr;
    logic          w_empty;
    logic          w_full;
    logic          w_hold;
    logic          w_ovld;
    logic          w_irdy;
    logic          w_wen;
    logic          w_ren;
    logic          w_byp;
    logic          w_wen_st;
    logic          w_ren_st;
    logic [DW-1:0] w_dat;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DP));
    assign w_hold  = rst | flush;

    assign w_ovld = ~w_hold & (~w_empty | ((BYPASS != 0) & i_vld));
    assign w_irdy = ~w_hold & ((CUT_READY != 0) ? ~w_full : (~w_full | o_rdy));

    assign w_wen = i_vld & w_irdy;
    assign w_ren = w_ovld & o_rdy;

    // A bypassed word is consumed straight from i_dat: no store, no pop.
    assign w_byp    = (BYPASS != 0) & w_empty & w_wen & w_ren;
    assign w_wen_st = w_wen & ~w_byp;
    assign w_ren_st = w_ren & ~w_empty;

    sirv_gnrl_wrap_ctr #(.MAX(DP), .W(PW)) u_rptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (w_ren_st),
      .val (w_rptr)
    );

    sirv_gnrl_wrap_ctr #(.MAX(DP), .W(PW)) u_wptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .inc (w_wen_st),
      .val (w_wptr)
    );

    always_ff @(posedge clk) begin
      if (w_hold) begin
        r_count <= '0;
      end else if (w_wen_st != w_ren_st) begin
        r_count <= w_wen_st ? r_count + CW'(1) : r_count - CW'(1);
      end
    end

    // When full with a pop, wptr==rptr: the read sees the old word this cycle.
    always_ff @(posedge clk) begin
      if (w_wen_st) begin
        r_mem[w_wptr] <= i_dat;
      end
    end

    assign w_dat  = w_empty ? i_dat : r_mem[w_rptr];
    assign o_dat  = ((MSKO != 0) && !w_ovld) ? '0 : w_dat;
    assign o_vld  = w_ovld;
    assign i_rdy  = w_irdy;
    assign count  = r_count;
    assign full   = w_full;
    assign empty  = w_empty;
    assign afull  = (r_count >= CW'(AF_LVL));
    assign aempty = (r_count <= CW'(AE_LVL));
  end

endmodule
